schedule_controller: RTL and testbench

Consumes parsed schedule records (zone, start, stop) from the SD-card line parser directly upstream, buffers them in an internal schedule table, and drives the four zone valves by comparing each record against the current time-of-day. It paces the parser through `read_next_line`, then re-evaluates the table on every time tick, opening at most one valve at a time.

---
 rtl/sprinkler_pkg.sv | 40 ++++
 rtl/schedule_table.sv | 24 ++
 rtl/schedule_controller.sv | 179 +++++++++++++++++
 tb/tb_schedule_controller.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprinkler_pkg.sv
// Shared types and constants for the sprinkler schedule controller.
package sprinkler_pkg;

  localparam int unsigned NUM_ZONES = 4;
  localparam int unsigned ZONE_W    = 2;
  localparam int unsigned DIGIT_W   = 8;
  localparam int unsigned TIME_W    = 4 * DIGIT_W;

  // Times are four ASCII digits HHMM, big-endian, so unsigned compares keep order.
  localparam logic [DIGIT_W-1:0] ASCII_ZERO    = 8'h30;
  localparam logic [TIME_W-1:0]  TIME_MIDNIGHT = {4{ASCII_ZERO}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SCAN_IDLE   = 2'd0,
    SCAN_CMP    = 2'd1,
    SCAN_COMMIT = 2'd2
  } scan_e;

  typedef struct packed {
    logic [ZONE_W-1:0] zone;
    logic [TIME_W-1:0] start;
    logic [TIME_W-1:0] stop;
  } entry_t;

  function automatic logic [NUM_ZONES-1:0] zone_onehot(input logic [ZONE_W-1:0] z);
    return NUM_ZONES'(1) << z;
  endfunction

  // Isolates the lowest set bit (two's complement trick).
  function automatic logic [NUM_ZONES-1:0] lowest_bit(input logic [NUM_ZONES-1:0] v);
    return v & (~v + NUM_ZONES'(1));
  endfunction

endpackage

// File: rtl/schedule_table.sv
// Schedule record storage: one synchronous write port, one combinational read port.
module schedule_table
  import sprinkler_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  entry_t            wdata,
  input  logic [ADDR_W-1:0] raddr,
  output entry_t            rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/schedule_controller.sv
// Schedule controller: loads parsed schedule records, then opens at most one
// zone valve per time tick by scanning the table against the sampled time.
module schedule_controller
  import sprinkler_pkg::*;
#(
  parameter int unsigned MAX_ENTRIES  = 8,
  parameter int unsigned LOAD_TIMEOUT = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load_start,
  output logic                             read_next_line,
  input  logic                             data_valid,
  input  logic [ZONE_W-1:0]                zone,
  input  logic [TIME_W-1:0]                start_time,
  input  logic [TIME_W-1:0]                stop_time,
  input  logic [TIME_W-1:0]                time_now,
  input  logic                             time_tick,
  input  logic                             enable,
  output logic [NUM_ZONES-1:0]             valve,
  output logic                             busy,
  output logic [$clog2(MAX_ENTRIES+1)-1:0] entry_count,
  output logic                             overflow
);

  localparam int unsigned CNT_W  = $clog2(MAX_ENTRIES + 1);
  localparam int unsigned IDX_W  = (MAX_ENTRIES > 1) ? $clog2(MAX_ENTRIES) : 1;
  localparam int unsigned IDLE_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  FULL      = CNT_W'(MAX_ENTRIES);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(LOAD_TIMEOUT - 1);

  state_e               state_q, state_d;
  scan_e                scan_q, scan_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [IDLE_W-1:0]    idle_q, idle_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TIME_W-1:0]    time_q, time_d;
  logic [NUM_ZONES-1:0] pend_q, pend_d;
  logic                 tick_pend_q, tick_pend_d;
  logic                 overflow_q, overflow_d;
  logic [NUM_ZONES-1:0] valve_q, valve_d;
  logic                 rnl_q, rnl_d;
  logic                 busy_q, busy_d;

  logic   tbl_we;
  logic   hit;
  entry_t wr_entry;
  entry_t rd_entry;

  assign wr_entry = {zone, start_time, stop_time};

  schedule_table #(
    .DEPTH  (MAX_ENTRIES),
    .ADDR_W (IDX_W)
  ) u_table (
    .clk   (clk),
    .we    (tbl_we),
    .waddr (IDX_W'(count_q)),
    .wdata (wr_entry),
    .raddr (idx_q),
    .rdata (rd_entry)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      scan_q      <= SCAN_IDLE;
      count_q     <= '0;
      idle_q      <= '0;
      idx_q       <= '0;
      time_q      <= TIME_MIDNIGHT;
      pend_q      <= '0;
      tick_pend_q <= 1'b0;
      overflow_q  <= 1'b0;
      valve_q     <= '0;
      rnl_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_q      <= scan_d;
      count_q     <= count_d;
      idle_q      <= idle_d;
      idx_q       <= idx_d;
      time_q      <= time_d;
      pend_q      <= pend_d;
      tick_pend_q <= tick_pend_d;
      overflow_q  <= overflow_d;
      valve_q     <= valve_d;
      rnl_q       <= rnl_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state: load sequencing, scan stepping and valve commit
  always_comb begin
    state_d     = state_q;
    scan_d      = scan_q;
    count_d     = count_q;
    idle_d      = idle_q;
    idx_d       = idx_q;
    time_d      = time_q;
    pend_d      = pend_q;
    tick_pend_d = tick_pend_q;
    overflow_d  = overflow_q;
    valve_d     = valve_q;
    tbl_we      = 1'b0;
    hit         = (rd_entry.start <= time_q) && (time_q < rd_entry.stop);

    if (load_start) begin
      state_d     = LOAD;
      scan_d      = SCAN_IDLE;
      count_d     = '0;
      idle_d      = '0;
      idx_d       = '0;
      pend_d      = '0;
      tick_pend_d = 1'b0;
      overflow_d  = 1'b0;
      valve_d     = '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (data_valid) begin
            idle_d = '0;
            if (count_q == FULL) begin
              overflow_d = 1'b1;
            end else if (stop_time > start_time) begin
              tbl_we  = 1'b1;
              count_d = count_q + CNT_W'(1);
            end
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
          if ((count_d == FULL) || (idle_q == IDLE_LAST)) state_d = RUN;
        end
        RUN: begin
          // Parser may still deliver a record after the table filled up.
          if (data_valid && (count_q == FULL)) overflow_d = 1'b1;
          case (scan_q)
            SCAN_IDLE: begin
              if (time_tick || tick_pend_q) begin
                time_d      = time_now;
                idx_d       = '0;
                pend_d      = '0;
                tick_pend_d = 1'b0;
                scan_d      = (count_q == '0) ? SCAN_COMMIT : SCAN_CMP;
              end
            end
            SCAN_CMP: begin
              tick_pend_d = tick_pend_q | time_tick;
              if (hit) pend_d = pend_q | zone_onehot(rd_entry.zone);
              if (idx_q == IDX_W'(count_q - CNT_W'(1))) scan_d = SCAN_COMMIT;
              else idx_d = idx_q + IDX_W'(1);
            end
            SCAN_COMMIT: begin
              tick_pend_d = tick_pend_q | time_tick;
              valve_d     = lowest_bit(pend_q);
              scan_d      = SCAN_IDLE;
            end
            default: scan_d = SCAN_IDLE;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end

    if (!enable) valve_d = '0;

    rnl_d  = (state_d == LOAD);
    busy_d = (state_d == LOAD) || (scan_d != SCAN_IDLE);
  end

  assign read_next_line = rnl_q;
  assign busy           = busy_q;
  assign entry_count    = count_q;
  assign overflow       = overflow_q;
  assign valve          = valve_q;

endmodule

// File: tb/tb_schedule_controller.sv
// Self-checking bench for schedule_controller: vector table plus scan scoreboard.
`timescale 1ns/1ps
module tb_schedule_controller;

  localparam int unsigned MAX_E = 8;
  localparam int unsigned CNT_W = $clog2(MAX_E + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             load_start;
  logic             read_next_line;
  logic             data_valid;
  logic [1:0]       zone;
  logic [31:0]      start_time;
  logic [31:0]      stop_time;
  logic [31:0]      time_now;
  logic             time_tick;
  logic             enable;
  logic [3:0]       valve;
  logic             busy;
  logic [CNT_W-1:0] entry_count;
  logic             overflow;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  typedef struct {
    logic [3:0]  valve;
    int unsigned due;
    string       name;
  } sb_t;
  sb_t sb_q[$];
  sb_t sb_item;

  typedef struct {
    logic [31:0] t;
    logic        en;
    logic [3:0]  exp;
  } vec_t;
  vec_t vecs[9];

  schedule_controller #(
    .MAX_ENTRIES  (MAX_E),
    .LOAD_TIMEOUT (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .load_start     (load_start),
    .read_next_line (read_next_line),
    .data_valid     (data_valid),
    .zone           (zone),
    .start_time     (start_time),
    .stop_time      (stop_time),
    .time_now       (time_now),
    .time_tick      (time_tick),
    .enable         (enable),
    .valve          (valve),
    .busy           (busy),
    .entry_count    (entry_count),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare valve when a scan's expected commit cycle arrives.
  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      sb_item = sb_q.pop_front();
      check(sb_item.name, 32'(valve), 32'(sb_item.valve));
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_tick(input logic [31:0] t, input logic [3:0] exp, input int unsigned n,
                         input string name);
    sb_t e;
    time_now  = t;
    time_tick = 1'b1;
    e.valve = exp;
    e.due   = cyc + n + 2;
    e.name  = name;
    sb_q.push_back(e);
    step();
    time_tick = 1'b0;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic send_rec(input logic [1:0] z, input logic [31:0] s, input logic [31:0] p);
    data_valid = 1'b1;
    zone       = z;
    start_time = s;
    stop_time  = p;
    step();
    data_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic        found;
    int unsigned busy_hi;

    vecs[0] = '{"0845", 1'b1, 4'b0010};
    vecs[1] = '{"0830", 1'b1, 4'b0010};
    vecs[2] = '{"0900", 1'b1, 4'b0100};
    vecs[3] = '{"0959", 1'b1, 4'b0100};
    vecs[4] = '{"1000", 1'b1, 4'b0000};
    vecs[5] = '{"0759", 1'b1, 4'b0000};
    vecs[6] = '{"0800", 1'b1, 4'b0010};
    vecs[7] = '{"0840", 1'b0, 4'b0000};
    vecs[8] = '{"0940", 1'b1, 4'b0100};

    rst = 1'b1; load_start = 1'b0; data_valid = 1'b0; zone = '0;
    start_time = '0; stop_time = '0; time_now = "0000"; time_tick = 1'b0; enable = 1'b1;
    step(3);
    check("rst_valve", 32'(valve), 32'd0);
    check("rst_rnl", 32'(read_next_line), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(entry_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    step();

    // Three-record load ending on idle timeout
    pulse_load();
    check("load_rnl_rise", 32'(read_next_line), 32'd1);
    check("load_busy", 32'(busy), 32'd1);
    send_rec(2'd1, "0800", "0900");
    check("count_1", 32'(entry_count), 32'd1);
    send_rec(2'd2, "0900", "1000");
    check("count_2", 32'(entry_count), 32'd2);
    send_rec(2'd3, "0830", "0845");
    check("count_3", 32'(entry_count), 32'd3);
    step(63);
    check("rnl_before_timeout", 32'(read_next_line), 32'd1);
    step();
    check("rnl_after_timeout", 32'(read_next_line), 32'd0);
    check("busy_in_run", 32'(busy), 32'd0);
    check("count_after_load", 32'(entry_count), 32'd3);

    // Exact scan latency: N=3 -> valve updates 5 cycles after the tick
    do_tick("0835", 4'b0010, 3, "scan_0835");
    check("busy_scan_start", 32'(busy), 32'd1);
    check("valve_early_1", 32'(valve), 32'd0);
    step(3);
    check("valve_early_4", 32'(valve), 32'd0);
    check("busy_commit_cycle", 32'(busy), 32'd1);
    step();
    check("busy_after_commit", 32'(busy), 32'd0);
    step();

    for (int i = 0; i < 9; i++) begin
      enable = vecs[i].en;
      do_tick(vecs[i].t, vecs[i].exp, 3, $sformatf("vec%0d", i));
      step(5);
    end

    // Overflow: nine valid records into an eight-entry table
    pulse_load();
    check("valve_cleared_by_load", 32'(valve), 32'd0);
    for (int i = 0; i < 8; i++) send_rec(2'd3, "0100", "0200");
    check("count_full", 32'(entry_count), 32'd8);
    check("rnl_drop_on_full", 32'(read_next_line), 32'd0);
    check("overflow_not_yet", 32'(overflow), 32'd0);
    send_rec(2'd0, "0300", "0400");
    check("count_stays_full", 32'(entry_count), 32'd8);
    check("overflow_set", 32'(overflow), 32'd1);
    do_tick("0330", 4'b0000, 8, "ninth_absent");
    step(11);
    do_tick("0130", 4'b1000, 8, "full_table_hit");
    step(11);

    // Mid-scan tick plus enable drop: one extra scan only
    time_now = "0130"; time_tick = 1'b1; step(); time_tick = 1'b0;
    step(2);
    time_tick = 1'b1; step(); time_tick = 1'b0;
    enable = 1'b0;
    step();
    check("valve_off_after_enable", 32'(valve), 32'd0);
    step(6);
    enable = 1'b1;
    found = 1'b0;
    for (int w = 0; w < 30 && !found; w++) begin
      step();
      if (valve == 4'b1000) found = 1'b1;
    end
    check("extra_scan_valve", 32'(found), 32'd1);
    busy_hi = 0;
    for (int w = 0; w < 15; w++) begin
      step();
      if (busy) busy_hi++;
    end
    check("no_third_scan", busy_hi, 32'd0);
    check("valve_held", 32'(valve), 32'b1000);

    // Reload clears overflow; inverted/empty windows are rejected
    pulse_load();
    check("overflow_cleared", 32'(overflow), 32'd0);
    check("count_cleared", 32'(entry_count), 32'd0);
    check("valve_cleared_2", 32'(valve), 32'd0);
    send_rec(2'd0, "1000", "0900");
    check("reject_inverted", 32'(entry_count), 32'd0);
    send_rec(2'd0, "0900", "0900");
    check("reject_equal", 32'(entry_count), 32'd0);
    step(64);
    check("rnl_empty_run", 32'(read_next_line), 32'd0);
    do_tick("0930", 4'b0000, 0, "empty_scan");
    check("busy_empty_scan", 32'(busy), 32'd1);
    step(3);

    // Asynchronous reset in the middle of a scan
    pulse_load();
    send_rec(2'd2, "0900", "1000");
    step(64);
    check("count_single", 32'(entry_count), 32'd1);
    do_tick("0930", 4'b0100, 1, "pre_rst_scan");
    step(4);
    check("valve_before_rst", 32'(valve), 32'b0100);
    time_tick = 1'b1; step(); time_tick = 1'b0;
    check("busy_mid_scan", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valve", 32'(valve), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_rnl", 32'(read_next_line), 32'd0);
    check("async_rst_count", 32'(entry_count), 32'd0);
    check("async_rst_overflow", 32'(overflow), 32'd0);
    step(2);
    rst = 1'b0;
    step();
    time_tick = 1'b1; step(); time_tick = 1'b0;
    step(4);
    check("idle_ignores_tick_busy", 32'(busy), 32'd0);
    check("idle_ignores_tick_valve", 32'(valve), 32'd0);
    check("idle_rnl_low", 32'(read_next_line), 32'd0);

    step(5);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
